// File: rtl/serial_add_sub_if.sv
// Operand/result handshake bundle for the digit-serial adder/subtractor.
interface serial_add_sub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;
    logic             Zero;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf, Zero
    );

    // The arithmetic block itself.
    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, S, Cout, Ovf, Zero
    );
endinterface

// File: rtl/serial_add_sub.sv
// Digit-serial add/subtract: DIGIT bits per cycle, LSB slice first, with
// carry, signed overflow and zero flags held until the next completion.
module serial_add_sub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 4
) (
    input logic             clk,
    input logic             rst,
    serial_add_sub_if.slave bus
);
    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept_c;
    logic             step_c;
    logic             last_c;

    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // already inverted for subtract
    logic [WIDTH-1:0] sum_q;    // slices assembled so far

    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic [31:0]      shift_c;
    logic [DIGIT-1:0] a_sl_c;
    logic [DIGIT-1:0] b_sl_c;
    logic [DIGIT:0]   full_c;
    logic [DIGIT-1:0] slice_c;
    logic             cdig_c;
    logic             ovf_c;
    logic [WIDTH-1:0] sum_next_c;

    // Handshake outputs decode the state register; reset blocks acceptance.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.Ovf       = ovf_q;
    assign bus.Zero      = zero_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        step_c   = 1'b0;
        last_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_c = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                step_c = 1'b1;
                if (idx_q == LAST_IDX) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One DIGIT-wide slice addition selected by the digit index.
    always_comb begin
        shift_c    = 32'(idx_q) * DIGIT;
        a_sl_c     = DIGIT'(a_q >> shift_c);
        b_sl_c     = DIGIT'(b_q >> shift_c);
        full_c     = {1'b0, a_sl_c} + {1'b0, b_sl_c} + (DIGIT + 1)'(carry_q);
        slice_c    = full_c[DIGIT-1:0];
        cdig_c     = full_c[DIGIT];
        // Same-sign operands producing a different-sign sum: equals the
        // carry into the MSB XOR the carry out of it.
        ovf_c      = (a_sl_c[DIGIT-1] == b_sl_c[DIGIT-1]) &&
                     (slice_c[DIGIT-1] != a_sl_c[DIGIT-1]);
        sum_next_c = sum_q | (WIDTH'(slice_c) << shift_c);
    end

    // Operand capture, slice accumulation and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept_c) begin
            // Subtract is A + ~B + ~Cin through the same adder.
            a_q     <= bus.A;
            b_q     <= bus.Sub ? ~bus.B : bus.B;
            carry_q <= bus.Sub ? ~bus.Cin : bus.Cin;
            idx_q   <= '0;
            sum_q   <= '0;
        end else if (step_c) begin
            carry_q <= cdig_c;
            sum_q   <= sum_next_c;
            idx_q   <= idx_q + IDX_W'(1);
            if (last_c) begin
                s_q    <= sum_next_c;
                cout_q <= cdig_c;
                ovf_q  <= ovf_c;
                zero_q <= (sum_next_c == '0);
            end
        end
    end
endmodule
